// File: rtl/v_tile_sequencer.sv
// Vector tile control sequencer.
// Takes one command word from the CGRA network, programs the adder mode,
// issues one start pulse per iteration, waits for the adder ack and drains
// the selected adder lanes to the network over a valid/ready port.
module v_tile_sequencer #(
    parameter int WIDTH   = 16,
    parameter int DEST_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [WIDTH-1:0]  cmd_word_i,
    output logic [1:0]        fu_mode_o,
    output logic              fu_start_o,
    input  logic              fu_ack_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        out_lane_o,
    output logic [DEST_W-1:0] out_dest_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_ACK = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic [3:0]          mask_q, mask_d;
    logic [4:0]          rem_q, rem_d;
    logic [1:0]          lane_q, lane_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                end_iter;
    logic [2:0]          lane_pick;

    // Upper command bits carry no meaning for this tile.
    logic cmd_unused;
    assign cmd_unused = ^cmd_word_i[WIDTH-1:14];

    // Lowest set mask bit at or above 'from'; bit 2 of the result flags a hit.
    function automatic logic [2:0] find_lane(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            dest_q  <= '0;
            mask_q  <= 4'b0000;
            rem_q   <= 5'd0;
            lane_q  <= 2'b00;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dest_q  <= dest_d;
            mask_q  <= mask_d;
            rem_q   <= rem_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: command intake, ack wait with timeout, lane drain, iteration bookkeeping.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        dest_d    = dest_q;
        mask_d    = mask_q;
        rem_d     = rem_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        end_iter  = 1'b0;
        lane_pick = 3'b000;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_word_i[1:0] == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = cmd_word_i[1:0];
                        dest_d  = DEST_W'(cmd_word_i[5:2]);
                        mask_d  = cmd_word_i[9:6];
                        rem_d   = {1'b0, cmd_word_i[13:10]} + 5'd1;
                        err_d   = 1'b0;
                        state_d = START;
                    end
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (fu_ack_i) begin
                    if (mask_q != 4'b0000) begin
                        lane_pick = find_lane(mask_q, 3'd0);
                        lane_d    = lane_pick[1:0];
                        state_d   = DRAIN;
                    end else begin
                        end_iter = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (out_ready_i) begin
                    lane_pick = find_lane(mask_q, {1'b0, lane_q} + 3'd1);
                    if (lane_pick[2]) begin
                        lane_d = lane_pick[1:0];
                    end else begin
                        end_iter = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (end_iter) begin
            if (rem_q <= 5'd1) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                rem_d   = rem_q - 5'd1;
                state_d = START;
            end
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign fu_start_o  = (state_q == START);
    assign out_valid_o = (state_q == DRAIN);
    assign busy_o      = (state_q != IDLE);
    assign fu_mode_o   = mode_q;
    assign out_lane_o  = lane_q;
    assign out_dest_o  = dest_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
